// File: rtl/i2c_bus_arb_if.sv
// Bus-side signal bundle for the I2C bus arbiter: synchronized SCL/SDA
// levels and local requests in, grant and bus-status pulses out.
interface i2c_bus_arb_if #(
  parameter int NUM_REQ_G = 2
);
  logic                 i_scl;
  logic                 i_sda;
  logic [NUM_REQ_G-1:0] i_req;
  logic [NUM_REQ_G-1:0] o_gnt;
  logic                 o_busy;
  logic                 o_start;
  logic                 o_stop;

  // Requester / bus-monitor side: drives the bus levels and requests.
  modport master (
    output i_scl, i_sda, i_req,
    input  o_gnt, o_busy, o_start, o_stop
  );

  // Arbiter side.
  modport slave (
    input  i_scl, i_sda, i_req,
    output o_gnt, o_busy, o_start, o_stop
  );
endinterface

// File: rtl/i2c_bus_arb.sv
// Shares one I2C bus between local masters and external masters.
// Watches START/STOP on the synchronized bus, tracks ownership and grants
// the bus round-robin to one local requester only when the bus is free.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HOLDOFF    | bus state unknown; waiting for enough idle cycles
// FREE       | bus idle long enough; a local request may be granted
// LOCAL      | bus owned by the granted local requester
// EXTERNAL   | an external master started a transfer
module i2c_bus_arb #(
  parameter int NUM_REQ_G         = 2,
  parameter int BUS_FREE_CYCLES_G = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  i2c_bus_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(BUS_FREE_CYCLES_G + 1);
  localparam int PTR_W = (NUM_REQ_G > 1) ? $clog2(NUM_REQ_G) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUS_FREE_CYCLES_G);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ_G - 1);

  typedef enum logic [1:0] {
    S_HOLDOFF,
    S_FREE,
    S_LOCAL,
    S_EXTERNAL
  } state_t;

  state_t               r_state;
  logic                 r_scl_q;
  logic                 r_sda_q;
  logic [CNT_W-1:0]     r_idle_cnt;
  logic [PTR_W-1:0]     r_ptr;
  logic [NUM_REQ_G-1:0] r_gnt;
  logic                 r_busy;
  logic                 r_start;
  logic                 r_stop;

  logic                 w_start;
  logic                 w_stop;
  logic                 w_idle;
  logic                 w_cnt_done;
  logic                 w_any;
  logic [PTR_W-1:0]     w_sel;

  assign w_start    = r_scl_q & bus.i_scl & r_sda_q & ~bus.i_sda;
  assign w_stop     = r_scl_q & bus.i_scl & ~r_sda_q & bus.i_sda;
  assign w_idle     = bus.i_scl & bus.i_sda;
  assign w_cnt_done = (r_idle_cnt == CNT_MAX);

  // Round-robin pick: first active request after the last-granted index.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int i = 1; i <= NUM_REQ_G; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ_G) idx = idx - NUM_REQ_G;
      if (!w_any && bus.i_req[PTR_W'(idx)]) begin
        w_any = 1'b1;
        w_sel = PTR_W'(idx);
      end
    end
  end

  // Bus monitor, idle counter and ownership FSM with registered outputs.
  // busy is written alongside every state change so it mirrors next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_HOLDOFF;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
      r_idle_cnt <= '0;
      r_ptr      <= PTR_RST;
      r_gnt      <= '0;
      r_busy     <= 1'b1;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_q <= bus.i_scl;
      r_sda_q <= bus.i_sda;
      r_start <= w_start;
      r_stop  <= w_stop;

      if (!w_idle)
        r_idle_cnt <= '0;
      else if (!w_cnt_done)
        r_idle_cnt <= r_idle_cnt + 1'b1;

      case (r_state)
        S_HOLDOFF: begin
          if (w_start) begin
            r_state <= S_EXTERNAL;
            r_busy  <= 1'b1;
          end else if (w_cnt_done) begin
            r_state <= S_FREE;
            r_busy  <= 1'b0;
          end
        end
        S_FREE: begin
          if (w_start) begin
            r_state <= S_EXTERNAL;
            r_busy  <= 1'b1;
          end else if (!w_idle) begin
            r_state    <= S_HOLDOFF;
            r_busy     <= 1'b1;
            r_idle_cnt <= '0;
          end else if (w_any) begin
            r_state <= S_LOCAL;
            r_busy  <= 1'b1;
            r_ptr   <= w_sel;
            r_gnt   <= NUM_REQ_G'(1) << w_sel;
          end
        end
        S_LOCAL: begin
          // The owner's own START/STOP are not ownership events here.
          if (!bus.i_req[r_ptr]) begin
            r_state    <= S_HOLDOFF;
            r_busy     <= 1'b1;
            r_gnt      <= '0;
            r_idle_cnt <= '0;
          end
        end
        S_EXTERNAL: begin
          if (w_stop) begin
            r_state    <= S_HOLDOFF;
            r_busy     <= 1'b1;
            r_idle_cnt <= '0;
          end else if (w_cnt_done) begin
            r_state <= S_FREE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_HOLDOFF;
          r_busy     <= 1'b1;
          r_gnt      <= '0;
          r_idle_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.o_gnt   = r_gnt;
  assign bus.o_busy  = r_busy;
  assign bus.o_start = r_start;
  assign bus.o_stop  = r_stop;

endmodule
